// File: rtl/bam_pkg.sv
// Shared types and helpers for the sequential broken-array multiplier.
package bam_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int MAXW = 128;

  function automatic int hw_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int vw_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  // Keeps columns v..w-1; any v >= w yields an all-zero mask.
  function automatic logic [MAXW-1:0] mask(input int v, input int w);
    logic [MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < MAXW; i++) m[i] = (i >= v) && (i < w);
    return m;
  endfunction

endpackage

// File: rtl/bam_row_gen.sv
// One partial-product row of the broken array: (b_bit ? a : 0) << j with low columns cut.
module bam_row_gen
  import bam_pkg::*;
#(
  parameter int N  = 8,
  parameter int JW = 4,
  parameter int VW = 5
) (
  input  logic [N-1:0]   a,
  input  logic           b_bit,
  input  logic [JW-1:0]  j,
  input  logic [VW-1:0]  v,
  output logic [2*N-1:0] row
);

  logic [2*N-1:0] shifted;
  logic [2*N-1:0] col_mask;

  always_comb begin
    shifted  = b_bit ? ({{N{1'b0}}, a} << j) : '0;
    col_mask = (2*N)'(mask(int'(v), 2 * N));
    row      = shifted & col_mask;
  end

endmodule

// File: rtl/u_seqbam_mul.sv
// Iterative unsigned broken-array multiplier: one partial-product row per cycle,
// with horizontal/vertical cut points chosen per operation.
module u_seqbam_mul
  import bam_pkg::*;
#(
  parameter int N  = 8,
  parameter int HW = hw_width(N),
  parameter int VW = vw_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [HW-1:0]  h_cut,
  input  logic [VW-1:0]  v_cut,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [VW-1:0]  v_q;
  logic [HW-1:0]  j;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] row;
  logic           b_bit;

  // j can exceed N-1 only outside RUN, where the selected bit is irrelevant.
  always_comb begin
    b_bit = 1'b0;
    for (int k = 0; k < N; k++)
      if (j == HW'(k)) b_bit = b_q[k];
  end

  bam_row_gen #(
    .N  (N),
    .JW (HW),
    .VW (VW)
  ) u_row_gen (
    .a     (a_q),
    .b_bit (b_bit),
    .j     (j),
    .v     (v_q),
    .row   (row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      j         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      v_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            v_q      <= v_cut;
            j        <= h_cut;
            acc      <= '0;
            in_ready <= 1'b0;
            if (32'(h_cut) < N) begin
              state <= RUN;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              p         <= '0;
            end
          end
        end
        RUN: begin
          acc <= acc + row;
          if (j == HW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            p         <= acc + row;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/u_seqbam_mul.md
# u_seqbam_mul

Iterative, runtime-configurable unsigned broken-array multiplier (BAM). It generalises our fixed combinational BAM arrays in three ways: operand width is parametrised, the horizontal and vertical cut points are per-operation inputs, and one partial-product row is accumulated per cycle behind a valid/ready handshake. It is intended for area-constrained datapaths where exact and approximate products share one unit and the error/latency trade-off is chosen at issue time.

## Interface
Parameters:
- `N`, 8: operand width; N ≥ 2.
- `HW`, $clog2(N+1): width of `h_cut`; derived, do not override.
- `VW`, $clog2(2N+1): width of `v_cut`; derived, do not override.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  unit idle, can accept an operation.
- `a`  in  N  multiplicand.
- `b`  in  N  multiplier; bit j selects row j.
- `h_cut`  in  HW  rows j < h_cut are omitted.
- `v_cut`  in  VW  columns i+j < v_cut are omitted.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `p`  out  2N  approximate product.

## Operation
- Result definition: p = Σ a[i]·b[j]·2^(i+j) over all i,j in [0,N) with j ≥ h_cut and i+j ≥ v_cut. Kept terms are summed exactly. h_cut=0, v_cut=0 gives the exact product.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: the unit accumulates rows.
  - DONE: out_valid=1.
- IDLE, in_valid=1 → latch a, b, h_cut, v_cut; acc←0; row counter j←h_cut. Next state is RUN if h_cut < N, else DONE (p=0).
- RUN, each cycle:
  - row = (b[j] ? a : 0) << j, zero-extended to 2N bits.
  - Clear row bits below position v_cut.
  - acc ← acc + row, in 2N-bit arithmetic. No overflow is possible because p ≤ a·b.
  - If j == N−1 → DONE, otherwise j ← j+1.
- DONE: p = acc, held stable while out_ready=0. When out_ready=1 → IDLE.
- Range rules for the cuts:
  - h_cut values > N behave as N.
  - v_cut ≥ 2N masks every column, so p=0.
- Cut inputs and operands are sampled only at acceptance. Later changes are ignored.
- in_ready is asserted only in IDLE. There is no overlap between result drain and the next accept.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, acc=0, j=0.
- Assertion of rst in any state (including mid-RUN or DONE with out_valid high) discards the operation. Reset values appear the cycle after rst is sampled high.
- Latency, with the accept edge at cycle k:
  - h_cut < N: RUN occupies cycles k+1 … k+(N−h_cut); out_valid rises at k+N−h_cut+1.
  - h_cut ≥ N: out_valid rises at k+1.
- Throughput: at most one operation per N−h_cut+2 cycles (accept, rows, result handshake, return to IDLE).
- in_valid while not IDLE is ignored. The requester must hold a/b/cuts until the accept edge.
- out_valid and p are registered outputs, with no combinational path from in_valid or out_ready.

## Structure
- Package `bam_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - Functions for HW/VW width derivation.
  - Column-mask function mask(v) = ~((1<<v)−1), 2N bits, saturating at v ≥ 2N.
- One combinational sub-module, `bam_row_gen`: (a, b_bit, j, v) → masked 2N-bit row.
- Top holds the FSM, acc, j and the latched operands.

## Test plan
- N=8, a=255, b=255, h_cut=3, v_cut=8 → p=62208 (0xF300), out_valid at accept+6. Exact value 65025 must not appear.
- N=8, a=200, b=123, h_cut=0, v_cut=0 → p=24600 (exact), out_valid at accept+9.
- N=8, a=0x80, b=0x80, h_cut=3, v_cut=8 → p=16384. Then h_cut=8 with any operands → p=0, out_valid at accept+1. Then v_cut=16 → p=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → p and out_valid stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 → in_ready=1 the next cycle.
- Reset mid-RUN (cycle accept+3) → next cycle in_ready=1, out_valid=0, p=0. A following operation gives the correct result.
- Random sweep: N=8 and N=5, all h_cut/v_cut combinations, random operands and ready stalls → p matches the formula above every time.
